wb_pci_master: RTL and testbench

WB_PCI_MASTER -- requirements
Module: wb_pci_master

---
 rtl/wb_pci_master.sv | 130 +++++++++++++
 tb/tb_wb_pci_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_pci_master.sv
// Command-to-Wishbone-style bus master: takes one upstream command at a time,
// drives a single strobe cycle with timeout, returns one response and then
// waits for the slave's ACK/VALID tail to clear before accepting again.
module wb_pci_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PHY_CLK33_I,
  input  logic        PHY_RST_I,
  input  logic        CMD_VALID_I,
  output logic        CMD_READY_O,
  input  logic        CMD_WE_I,
  input  logic [31:0] CMD_ADD_I,
  input  logic [31:0] CMD_DATA_I,
  output logic        RSP_VALID_O,
  input  logic        RSP_READY_I,
  output logic [31:0] RSP_DATA_O,
  output logic        RSP_ERR_O,
  output logic [31:0] WB_ADD_O,
  output logic [31:0] WB_DATA_O,
  input  logic [31:0] WB_DATA_I,
  output logic        WB_STB_O,
  output logic        WB_WE_O,
  input  logic        WB_ACK_I,
  input  logic        WB_VALID_I
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, STROBE, RESP, RECOVER} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          cmd_ready_n, rsp_valid_n, rsp_err_n, stb_n, we_n;
  logic [31:0]   rsp_data_n, add_n, wdata_n;
  logic          term;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_ready_n = CMD_READY_O;
    rsp_valid_n = RSP_VALID_O;
    rsp_err_n   = RSP_ERR_O;
    rsp_data_n  = RSP_DATA_O;
    stb_n       = WB_STB_O;
    we_n        = WB_WE_O;
    add_n       = WB_ADD_O;
    wdata_n     = WB_DATA_O;
    cnt_inc     = cnt + CW'(1);
    term        = WB_WE_O ? WB_ACK_I : WB_VALID_I;

    case (state)
      IDLE: begin
        if (CMD_VALID_I && CMD_READY_O) begin
          state_n     = STROBE;
          cmd_ready_n = 1'b0;
          cnt_n       = '0;
          stb_n       = 1'b1;
          we_n        = CMD_WE_I;
          add_n       = CMD_ADD_I;
          wdata_n     = CMD_WE_I ? CMD_DATA_I : '0;
        end else begin
          cmd_ready_n = 1'b1;
        end
      end

      STROBE: begin
        // Termination is checked first so it wins over a coincident timeout.
        if (term || cnt_inc == LIMIT) begin
          state_n     = RESP;
          stb_n       = 1'b0;
          wdata_n     = '0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = !term;
          rsp_data_n  = (term && !WB_WE_O) ? WB_DATA_I : '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      RESP: begin
        if (RSP_READY_I) begin
          state_n     = RECOVER;
          rsp_valid_n = 1'b0;
          cnt_n       = '0;
        end
      end

      RECOVER: begin
        if ((!WB_ACK_I && !WB_VALID_I) || cnt_inc == LIMIT) begin
          state_n     = IDLE;
          cmd_ready_n = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
    if (PHY_RST_I) begin
      state       <= IDLE;
      cnt         <= '0;
      CMD_READY_O <= 1'b0;
      RSP_VALID_O <= 1'b0;
      RSP_ERR_O   <= 1'b0;
      RSP_DATA_O  <= '0;
      WB_STB_O    <= 1'b0;
      WB_WE_O     <= 1'b0;
      WB_ADD_O    <= '0;
      WB_DATA_O   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      CMD_READY_O <= cmd_ready_n;
      RSP_VALID_O <= rsp_valid_n;
      RSP_ERR_O   <= rsp_err_n;
      RSP_DATA_O  <= rsp_data_n;
      WB_STB_O    <= stb_n;
      WB_WE_O     <= we_n;
      WB_ADD_O    <= add_n;
      WB_DATA_O   <= wdata_n;
    end
  end

endmodule

// File: tb/tb_wb_pci_master.sv
// Bench for wb_pci_master: one-cycle registered slave plus a transaction-level
// reference (memory array, expected strobe length and response per command).
module tb_wb_pci_master;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_add = '0, cmd_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_data, wb_add, wb_wdata, wb_rdata;
  logic        wb_stb, wb_we, wb_ack, wb_vld;
  logic        silent = 1'b0;

  logic [31:0] smem [16];
  logic [31:0] ref_mem [16];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  wb_pci_master #(.TIMEOUT_CYCLES(TO)) dut (
    .PHY_CLK33_I(clk),
    .PHY_RST_I  (rst),
    .CMD_VALID_I(cmd_valid),
    .CMD_READY_O(cmd_ready),
    .CMD_WE_I   (cmd_we),
    .CMD_ADD_I  (cmd_add),
    .CMD_DATA_I (cmd_data),
    .RSP_VALID_O(rsp_valid),
    .RSP_READY_I(rsp_ready),
    .RSP_DATA_O (rsp_data),
    .RSP_ERR_O  (rsp_err),
    .WB_ADD_O   (wb_add),
    .WB_DATA_O  (wb_wdata),
    .WB_DATA_I  (wb_rdata),
    .WB_STB_O   (wb_stb),
    .WB_WE_O    (wb_we),
    .WB_ACK_I   (wb_ack),
    .WB_VALID_I (wb_vld)
  );

  always #5 clk = ~clk;

  // One-cycle registered slave: ACK/VALID follow STB by one edge, so they
  // linger for one cycle after STB falls.
  always @(posedge clk) begin
    if (rst) begin
      wb_ack <= 1'b0;
      wb_vld <= 1'b0;
      wb_rdata <= '0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      wb_ack   <= wb_stb && wb_we && !silent;
      wb_vld   <= wb_stb && !wb_we && !silent;
      wb_rdata <= (wb_stb && !wb_we && !silent) ? smem[wb_add[5:2]] : $urandom;
      if (wb_stb && wb_we && !silent) smem[wb_add[5:2]] <= wb_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command and check the whole bus cycle and response against the
  // reference; bp = cycles RSP_READY_I is withheld after the response appears.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                     input int bp);
    logic [31:0] exp_data, exp_wdata, held_data;
    logic        exp_err, stable;
    int          n, stb_len, exp_len;
    exp_err   = silent;
    exp_data  = (silent || we) ? 32'h0 : ref_mem[addr[5:2]];
    exp_wdata = we ? data : 32'h0;
    exp_len   = silent ? int'(TO) : 2;

    cmd_valid = 1'b1; cmd_we = we; cmd_add = addr; cmd_data = data;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0; cmd_add = $urandom; cmd_data = $urandom; cmd_we = ~we;

    chk("stb_rise", 32'(wb_stb), 32'd1);
    chk("ready_drop", 32'(cmd_ready), 32'd0);
    chk("stb_add", wb_add, addr);
    chk("stb_we", 32'(wb_we), 32'(we));
    chk("stb_wdata", wb_wdata, exp_wdata);
    chk("no_stale_tail", 32'({wb_ack, wb_vld}), 32'd0);

    stb_len = 1; stable = 1'b1;
    while (wb_stb && stb_len < 40) begin
      if (wb_add !== addr || wb_we !== we || wb_wdata !== exp_wdata ||
          rsp_valid !== 1'b0 || cmd_ready !== 1'b0) stable = 1'b0;
      tick();
      if (wb_stb) stb_len++;
    end
    chk("stb_stable", 32'(stable), 32'd1);
    chk("stb_len", 32'(stb_len), 32'(exp_len));
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_data", rsp_data, exp_data);
    chk("wdata_clr", wb_wdata, 32'h0);
    chk("add_kept", wb_add, addr);

    held_data = rsp_data; stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_err !== exp_err ||
          cmd_ready !== 1'b0 || wb_stb !== 1'b0) stable = 1'b0;
    end
    chk("rsp_hold", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_consumed", 32'(rsp_valid), 32'd0);
    chk("ready_low_recover", 32'(cmd_ready), 32'd0);

    if (we && !silent) ref_mem[addr[5:2]] = data;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    // Reset state, then ready one edge after release.
    #3;
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, wb_we}), 32'd0);
    chk("rst_buses", wb_add | wb_wdata | rsp_data, 32'h0);
    tick(); tick();
    rst = 1'b0;
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    tick();
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    // Directed write/read, timeout, backpressure.
    txn(1'b1, 32'h4, 32'h12345678, 0);
    txn(1'b0, 32'h4, 32'h0, 0);
    silent = 1'b1;
    txn(1'b0, 32'h8, 32'h0, 0);
    txn(1'b1, 32'hC, 32'hDEADBEEF, 1);
    silent = 1'b0;
    txn(1'b1, 32'h10, 32'hA5A5_5A5A, 5);
    txn(1'b0, 32'h10, 32'h0, 5);
    txn(1'b0, 32'hC, 32'h0, 0);

    // Reset in the middle of a strobe.
    silent = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_add = 32'h20; cmd_data = 32'h11;
    while (!cmd_ready) tick();
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("mid_stb_high", 32'(wb_stb), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_stb_drop", 32'(wb_stb), 32'd0);
    chk("async_rsp_low", 32'(rsp_valid), 32'd0);
    chk("async_add_clr", wb_add, 32'h0);
    tick(); tick();
    rst = 1'b0;
    silent = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    tick();
    chk("ready_after_abort", 32'(cmd_ready), 32'd1);
    chk("no_aborted_rsp", 32'(rsp_valid), 32'd0);

    // Randomized back-to-back traffic.
    for (int k = 0; k < 24; k++) begin
      logic        r_we;
      logic [31:0] r_add, r_data;
      r_we   = 1'($urandom_range(0, 1));
      r_add  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      r_data = $urandom;
      silent = ($urandom_range(0, 7) == 0);
      txn(r_we, r_add, r_data, int'($urandom_range(0, 3)));
    end
    silent = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
